// File: rtl/pulse_gen_multi_if.sv
// Bundle of the pulse generator's run controls, config write port and per-channel outputs.
// master drives the controls (stimulus side), slave is the generator itself.
interface pulse_gen_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                enable;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] trigger;
  logic                cfg_we;
  logic [SEL_W-1:0]    cfg_sel;
  logic [CNT_W-1:0]    cfg_delay;
  logic [CNT_W-1:0]    cfg_width;
  logic [CHANNELS-1:0] signal;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;

  modport master (
    output enable, mode, trigger, cfg_we, cfg_sel, cfg_delay, cfg_width,
    input  signal, busy, done
  );

  modport slave (
    input  enable, mode, trigger, cfg_we, cfg_sel, cfg_delay, cfg_width,
    output signal, busy, done
  );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: per-channel IDLE/DELAY/HIGH FSM, delay/width latched at start.
// Outputs registered; signal rises D+1 edges after the trigger edge and stays high W cycles.
module pulse_gen_multi #(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int DEF_DELAY = 36,
  parameter int DEF_WIDTH = 36
) (
  input logic               clock,
  input logic               reset_n,
  pulse_gen_multi_if.slave  bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CNT_W-1:0]    dl_q    [CHANNELS];
  logic [CNT_W-1:0]    dl_d    [CHANNELS];
  logic [CNT_W-1:0]    wl_q    [CHANNELS];
  logic [CNT_W-1:0]    wl_d    [CHANNELS];
  logic [CNT_W-1:0]    cfg_d_q [CHANNELS];
  logic [CNT_W-1:0]    cfg_w_q [CHANNELS];
  logic [CHANNELS-1:0] signal_q, signal_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic                periodic, retrig;

  assign periodic = (bus.mode == 2'd1);
  assign retrig   = (bus.mode == 2'd2);

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      dl_d[i]     = dl_q[i];
      wl_d[i]     = wl_q[i];
      signal_d[i] = signal_q[i];
      done_d[i]   = 1'b0;
      if (!bus.enable) begin
        state_d[i]  = IDLE;
        cnt_d[i]    = '0;
        signal_d[i] = 1'b0;
      // A retrigger never pre-empts the DELAY->HIGH step, so D=0 still produces a rise.
      end else if (bus.trigger[i] &&
                   (state_q[i] == IDLE ||
                    (retrig && !(state_q[i] == DELAY && cnt_q[i] == '0)))) begin
        state_d[i]  = DELAY;
        cnt_d[i]    = cfg_d_q[i];
        dl_d[i]     = cfg_d_q[i];
        wl_d[i]     = (cfg_w_q[i] == '0) ? CNT_W'(1) : cfg_w_q[i];
        signal_d[i] = 1'b0;
      end else begin
        case (state_q[i])
          DELAY: begin
            if (cnt_q[i] == '0) begin
              state_d[i]  = HIGH;
              signal_d[i] = 1'b1;
              cnt_d[i]    = wl_q[i] - CNT_W'(1);
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          HIGH: begin
            if (cnt_q[i] == '0) begin
              signal_d[i] = 1'b0;
              done_d[i]   = 1'b1;
              if (periodic) begin
                state_d[i] = DELAY;
                cnt_d[i]   = dl_q[i];
              end else begin
                state_d[i] = IDLE;
              end
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        dl_q[i]    <= '0;
        wl_q[i]    <= '0;
        cfg_d_q[i] <= CNT_W'(DEF_DELAY);
        cfg_w_q[i] <= CNT_W'(DEF_WIDTH);
      end
      signal_q <= '0;
      done_q   <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        dl_q[i]    <= dl_d[i];
        wl_q[i]    <= wl_d[i];
        if (bus.cfg_we && bus.cfg_sel == SEL_W'(i)) begin
          cfg_d_q[i] <= bus.cfg_delay;
          cfg_w_q[i] <= bus.cfg_width;
        end
      end
      signal_q <= signal_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    bus.busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.busy[i] = (state_q[i] != IDLE);
    end
  end

  assign bus.signal = signal_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: each step drives inputs after an edge and checks
// hand-computed signal/busy/done values 1 ns after the following edges.
module tb_pulse_gen_multi;
  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  pulse_gen_multi_if #(.CHANNELS(4), .CNT_W(8)) bus ();

  pulse_gen_multi #(.CHANNELS(4), .CNT_W(8), .DEF_DELAY(36), .DEF_WIDTH(36)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [7:0] d, input logic [7:0] w);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_delay = d;
    bus.cfg_width = w;
    tick(1);
    bus.cfg_we    = 1'b0;
  endtask

  // Raise trigger bits for exactly one sampling edge (that edge is "k").
  task automatic fire(input logic [3:0] t);
    bus.trigger = t;
    tick(1);
    bus.trigger = 4'h0;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.enable    = 1'b1;
    bus.mode      = 2'd0;
    bus.trigger   = 4'hF;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = '0;
    bus.cfg_delay = '0;
    bus.cfg_width = '0;
    #2;

    // Reset held 3 edges with all triggers high
    tick(3);
    chk("rst_signal", 32'(bus.signal), 32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_done",   32'(bus.done),   32'h0);
    reset_n     = 1'b1;
    bus.trigger = 4'h0;
    tick(1);

    // Default config 36/36 on ch0: rise at k+37, fall at k+73
    fire(4'h1);
    chk("def_busy_k",    32'(bus.busy[0]),   32'h1);
    tick(36);
    chk("def_sig_k36",   32'(bus.signal[0]), 32'h0);
    tick(1);
    chk("def_sig_k37",   32'(bus.signal[0]), 32'h1);
    tick(35);
    chk("def_sig_k72",   32'(bus.signal[0]), 32'h1);
    chk("def_done_k72",  32'(bus.done[0]),   32'h0);
    tick(1);
    chk("def_sig_k73",   32'(bus.signal[0]), 32'h0);
    chk("def_done_k73",  32'(bus.done[0]),   32'h1);
    chk("def_busy_k73",  32'(bus.busy[0]),   32'h0);
    tick(1);
    chk("def_done_k74",  32'(bus.done[0]),   32'h0);

    // One-shot ch1 D=2 W=3, second trigger at k+2 ignored
    cfg(2'd1, 8'd2, 8'd3);
    fire(4'h2);
    chk("os_sig_k",      32'(bus.signal[1]), 32'h0);
    tick(1);
    fire(4'h2);
    chk("os_sig_k2",     32'(bus.signal[1]), 32'h0);
    chk("os_busy_k2",    32'(bus.busy[1]),   32'h1);
    tick(1);
    chk("os_sig_k3",     32'(bus.signal[1]), 32'h1);
    tick(2);
    chk("os_sig_k5",     32'(bus.signal[1]), 32'h1);
    tick(1);
    chk("os_sig_k6",     32'(bus.signal[1]), 32'h0);
    chk("os_done_k6",    32'(bus.done[1]),   32'h1);
    tick(1);
    chk("os_busy_k7",    32'(bus.busy[1]),   32'h0);
    chk("os_done_k7",    32'(bus.done[1]),   32'h0);

    // Periodic ch2 D=1 W=2: rises k+2, k+6; done k+4; enable drop before k+8
    cfg(2'd2, 8'd1, 8'd2);
    bus.mode = 2'd1;
    fire(4'h4);
    tick(1);
    chk("per_sig_k1",    32'(bus.signal[2]), 32'h0);
    tick(1);
    chk("per_sig_k2",    32'(bus.signal[2]), 32'h1);
    tick(2);
    chk("per_sig_k4",    32'(bus.signal[2]), 32'h0);
    chk("per_done_k4",   32'(bus.done[2]),   32'h1);
    chk("per_busy_k4",   32'(bus.busy[2]),   32'h1);
    tick(1);
    chk("per_done_k5",   32'(bus.done[2]),   32'h0);
    tick(1);
    chk("per_sig_k6",    32'(bus.signal[2]), 32'h1);
    tick(1);
    bus.enable = 1'b0;
    tick(1);
    chk("per_en_sig",    32'(bus.signal[2]), 32'h0);
    chk("per_en_busy",   32'(bus.busy[2]),   32'h0);
    chk("per_en_done",   32'(bus.done[2]),   32'h0);
    bus.enable = 1'b1;
    bus.mode   = 2'd0;

    // Retrigger ch3 D=4 W=4: triggers at edges 0 and 3, rise 8, fall 12
    cfg(2'd3, 8'd4, 8'd4);
    bus.mode = 2'd2;
    fire(4'h8);
    tick(2);
    fire(4'h8);
    tick(2);
    chk("rt_sig_5",      32'(bus.signal[3]), 32'h0);
    tick(2);
    chk("rt_sig_7",      32'(bus.signal[3]), 32'h0);
    tick(1);
    chk("rt_sig_8",      32'(bus.signal[3]), 32'h1);
    chk("rt_done_8",     32'(bus.done[3]),   32'h0);
    tick(3);
    chk("rt_sig_11",     32'(bus.signal[3]), 32'h1);
    tick(1);
    chk("rt_sig_12",     32'(bus.signal[3]), 32'h0);
    chk("rt_done_12",    32'(bus.done[3]),   32'h1);
    tick(1);
    chk("rt_done_13",    32'(bus.done[3]),   32'h0);
    bus.mode = 2'd0;

    // D=0 W=0 on ch1: one-cycle pulse at k+1
    cfg(2'd1, 8'd0, 8'd0);
    fire(4'h2);
    chk("d0_busy_k",     32'(bus.busy[1]),   32'h1);
    chk("d0_sig_k",      32'(bus.signal[1]), 32'h0);
    tick(1);
    chk("d0_sig_k1",     32'(bus.signal[1]), 32'h1);
    tick(1);
    chk("d0_sig_k2",     32'(bus.signal[1]), 32'h0);
    chk("d0_done_k2",    32'(bus.done[1]),   32'h1);

    // Mode 0 trigger held: restart on the edge after done
    bus.trigger = 4'h2;
    tick(1);
    tick(1);
    chk("hold_sig_k1",   32'(bus.signal[1]), 32'h1);
    tick(1);
    chk("hold_done_k2",  32'(bus.done[1]),   32'h1);
    chk("hold_busy_k2",  32'(bus.busy[1]),   32'h0);
    tick(1);
    chk("hold_busy_k3",  32'(bus.busy[1]),   32'h1);
    tick(1);
    chk("hold_sig_k4",   32'(bus.signal[1]), 32'h1);
    bus.trigger = 4'h0;
    tick(2);

    // D=255 W=255 on ch1: rise k+256, fall k+511
    cfg(2'd1, 8'd255, 8'd255);
    fire(4'h2);
    tick(255);
    chk("max_sig_k255",  32'(bus.signal[1]), 32'h0);
    tick(1);
    chk("max_sig_k256",  32'(bus.signal[1]), 32'h1);
    tick(254);
    chk("max_sig_k510",  32'(bus.signal[1]), 32'h1);
    tick(1);
    chk("max_sig_k511",  32'(bus.signal[1]), 32'h0);
    chk("max_done_k511", 32'(bus.done[1]),   32'h1);

    // Reset mid-pulse, then config back at 36/36
    cfg(2'd1, 8'd0, 8'd3);
    fire(4'h2);
    tick(1);
    chk("mr_sig_pre",    32'(bus.signal[1]), 32'h1);
    reset_n = 1'b0;
    tick(1);
    chk("mr_signal",     32'(bus.signal),    32'h0);
    chk("mr_busy",       32'(bus.busy),      32'h0);
    chk("mr_done",       32'(bus.done),      32'h0);
    reset_n = 1'b1;
    tick(1);
    fire(4'h2);
    tick(36);
    chk("mr_sig_k36",    32'(bus.signal[1]), 32'h0);
    tick(1);
    chk("mr_sig_k37",    32'(bus.signal[1]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
